fu_alu_issue_arbiter: RTL and testbench
=======================================

// Module: fu_alu_issue_arbiter
// PURPOSE
//  Shares the single multi-cycle integer ALU functional unit among NREQ reservation-station requesters.
//  - Picks one ready requester and drives the ALU enable, opcode and operands for exactly one cycle.
//  - Times the ALU latency, then captures the result and holds it on the writeback/CDB interface until acknowledged.
//  - Sits between the issue/reservation-station logic and the ALU functional unit.
// PARAMETERS
//  NREQ     4   number of requesters (>=2)
//  TAG_W    3   reservation-station tag width
//  LATENCY  2   cycles from fu_en cycle to valid ALU result (>=2; the ALU needs one idle cycle between enables)
// PORTS
//  clk          in   1            clock, rising edge
//  rst_n        in   1            synchronous reset, active-low
//  req_valid    in   NREQ         requester i has a ready op
//  req_ctrl     in   4*NREQ       ALU opcode per requester (slice i = [4i+3:4i])
//  req_a        in   32*NREQ      operand A per requester
//  req_b        in   32*NREQ      operand B per requester
//  req_tag      in   TAG_W*NREQ   destination tag per requester
//  req_grant    out  NREQ         one-hot; requester i was accepted this cycle
//  fu_en        out  1            ALU enable (one-cycle pulse)
//  fu_ctrl      out  4            ALU opcode
//  fu_a, fu_b   out  32           ALU operands
//  fu_res       in   32           ALU result
//  fu_zero      in   1            ALU zero flag
//  fu_overflow  in   1            ALU overflow flag
//  wb_valid     out  1            result available on CDB
//  wb_tag       out  TAG_W        tag of result
//  wb_data      out  32           result value
//  wb_zero      out  1            captured zero flag
//  wb_overflow  out  1            captured overflow flag
//  wb_ack       in   1            CDB accepted result (sampled only when wb_valid=1)
//  busy         out  1            FSM not in IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): FSM=IDLE, cnt=0, rr_ptr=0.
//    - All outputs 0: wb_valid, wb_tag, wb_data, wb_zero, wb_overflow, busy, req_grant, fu_en.
//    - Reset mid-operation abandons the in-flight op; its result is never written back.
//  - States: IDLE -> EXEC -> WB -> IDLE/EXEC.
//  - ISSUE: in IDLE, or in WB with wb_ack=1, when any req_valid=1:
//    - The selected index s gets req_grant[s]=1 and fu_en=1 combinationally in that cycle.
//    - fu_ctrl/fu_a/fu_b equal slice s in that cycle; the outputs are 0 when fu_en=0.
//    - req_tag[s] is latched and cnt is loaded with LATENCY-1.
//    - The FSM goes to EXEC.
//  - EXEC: cnt decrements each cycle. On the cycle where cnt==1:
//    - fu_res, fu_zero, fu_overflow and the latched tag are registered into the wb_* outputs.
//    - The FSM goes to WB, so wb_valid rises LATENCY cycles after the issue cycle.
//  - WB: wb_valid=1 and all wb_* outputs hold stable until wb_ack=1.
//    - ack without a new request -> IDLE, wb_valid=0 next cycle.
//    - ack with a pending request -> same-cycle issue, back-to-back throughput of one op per LATENCY cycles.
//  - No grant is given while in EXEC, or in WB with wb_ack=0. Requesters must hold req_valid and operands until granted.
//  - req_grant is always one-hot or zero. A requester that drops req_valid before grant is simply skipped.
//  - busy = (FSM != IDLE).
// CONFIGURATION
//  FU_ALU_RR_EN defined:
//  - Round-robin: search starts at rr_ptr and wraps modulo NREQ.
//  - On each grant, rr_ptr <= (s+1) mod NREQ.
//  FU_ALU_RR_EN undefined:
//  - Fixed priority: lowest-index valid requester wins.
//  - rr_ptr is unused and the round-robin logic is removed.
// TESTING
//  1. req_valid=0001, ADD(0001) a=5 b=7 tag=3, wb_ack=1
//     -> req_grant=0001 and fu_en=1 in cycle 0; wb_valid=1, wb_data=12, wb_tag=3 in cycle 2; IDLE in cycle 3.
//  2. As 1, wb_ack=0 for 5 cycles while req_valid=0010
//     -> wb_valid, wb_data=12 and wb_tag stable; req_grant=0 and busy=1 throughout.
//     -> grant[1] in the same cycle ack rises.
//  3. FU_ALU_RR_EN, req_valid=1111 held, wb_ack=1 -> grants 0,1,2,3,0 every 2 cycles.
//     Without the macro -> grant[0] every 2 cycles.
//  4. SUB(0010) a=0x80000000 b=1 -> wb_data=0x7FFFFFFF, wb_overflow=1, wb_zero=0.
//     SUB a=b=9 -> wb_data=0, wb_zero=1.
//  5. rst_n=0 for one cycle during EXEC -> next cycle busy=0 and wb_valid=0, and no stale writeback later.
//     A following ADD 1+1 -> wb_data=2.
//  6. LATENCY=4, single ADD -> wb_valid rises exactly 4 cycles after fu_en.

Source files
------------

// File: rtl/fu_alu_issue_arbiter_if.sv
// Requester, ALU and CDB writeback bundle for fu_alu_issue_arbiter.
// master: the arbiter side. slave: the reservation stations, ALU and CDB around it.
interface fu_alu_issue_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned TAG_W = 3
);
   // reservation-station requesters
   logic [NREQ-1:0]       req_valid;
   logic [4*NREQ-1:0]     req_ctrl;
   logic [32*NREQ-1:0]    req_a;
   logic [32*NREQ-1:0]    req_b;
   logic [TAG_W*NREQ-1:0] req_tag;
   logic [NREQ-1:0]       req_grant;

   // shared ALU functional unit
   logic                  fu_en;
   logic [3:0]            fu_ctrl;
   logic [31:0]           fu_a;
   logic [31:0]           fu_b;
   logic [31:0]           fu_res;
   logic                  fu_zero;
   logic                  fu_overflow;

   // CDB writeback
   logic                  wb_valid;
   logic [TAG_W-1:0]      wb_tag;
   logic [31:0]           wb_data;
   logic                  wb_zero;
   logic                  wb_overflow;
   logic                  wb_ack;

   logic                  busy;

   modport master (
      input  req_valid, req_ctrl, req_a, req_b, req_tag,
      output req_grant,
      output fu_en, fu_ctrl, fu_a, fu_b,
      input  fu_res, fu_zero, fu_overflow,
      output wb_valid, wb_tag, wb_data, wb_zero, wb_overflow,
      input  wb_ack,
      output busy
   );

   modport slave (
      output req_valid, req_ctrl, req_a, req_b, req_tag,
      input  req_grant,
      input  fu_en, fu_ctrl, fu_a, fu_b,
      output fu_res, fu_zero, fu_overflow,
      input  wb_valid, wb_tag, wb_data, wb_zero, wb_overflow,
      output wb_ack,
      input  busy
   );
endinterface

// File: rtl/fu_alu_issue_arbiter.sv
// Issue arbiter for the single multi-cycle integer ALU shared by NREQ reservation stations.
// Grants one ready requester, pulses the ALU for one cycle, times LATENCY, then holds the
// captured result on the CDB until acknowledged.
// Build option: FU_ALU_RR_EN selects round-robin arbitration; otherwise fixed priority (index 0 highest).
module fu_alu_issue_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TAG_W   = 3,
   parameter int unsigned LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fu_alu_issue_arbiter_if.master bus
);
   localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned CTRL_W = 4;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic                wb_valid_q, wb_valid_d;
   logic [TAG_W-1:0]    wb_tag_q, wb_tag_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic                wb_zero_q, wb_zero_d;
   logic                wb_overflow_q, wb_overflow_d;
   logic                busy_q, busy_d;
`ifdef FU_ALU_RR_EN
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

   int unsigned         cand_c;
   logic                sel_found_c;
   logic [IDX_W-1:0]    sel_idx_c;
   logic                issue_c;
   logic [NREQ-1:0]     req_grant_c;
   logic                fu_en_c;
   logic [CTRL_W-1:0]   fu_ctrl_c;
   logic [DATA_W-1:0]   fu_a_c;
   logic [DATA_W-1:0]   fu_b_c;

   // Pick the winning requester: search from rr_ptr with wrap, or from index 0
   always_comb begin
      cand_c      = 0;
      sel_found_c = 1'b0;
      sel_idx_c   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef FU_ALU_RR_EN
         cand_c = (32'(rr_ptr_q) + k) % NREQ;
`else
         cand_c = k;
`endif
         if (!sel_found_c && bus.req_valid[IDX_W'(cand_c)]) begin
            sel_found_c = 1'b1;
            sel_idx_c   = IDX_W'(cand_c);
         end
      end
   end

   // Next state, writeback capture and the single-cycle issue drive
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tag_d         = tag_q;
      wb_valid_d    = wb_valid_q;
      wb_tag_d      = wb_tag_q;
      wb_data_d     = wb_data_q;
      wb_zero_d     = wb_zero_q;
      wb_overflow_d = wb_overflow_q;
`ifdef FU_ALU_RR_EN
      rr_ptr_d      = rr_ptr_q;
`endif
      issue_c       = 1'b0;
      req_grant_c   = '0;
      fu_en_c       = 1'b0;
      fu_ctrl_c     = '0;
      fu_a_c        = '0;
      fu_b_c        = '0;

      case (state_q)
         IDLE: begin
            issue_c = sel_found_c;
         end
         EXEC: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Last EXEC cycle: the ALU result is valid, register it onto the CDB
            if (cnt_q == CNT_W'(1)) begin
               wb_valid_d    = 1'b1;
               wb_tag_d      = tag_q;
               wb_data_d     = bus.fu_res;
               wb_zero_d     = bus.fu_zero;
               wb_overflow_d = bus.fu_overflow;
               state_d       = WB;
            end
         end
         WB: begin
            // Result held until the CDB takes it; an ack frees the ALU for a same-cycle issue
            if (bus.wb_ack) begin
               wb_valid_d = 1'b0;
               state_d    = IDLE;
               issue_c    = sel_found_c;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (issue_c) begin
         req_grant_c = NREQ'(1) << sel_idx_c;
         fu_en_c     = 1'b1;
         fu_ctrl_c   = CTRL_W'(bus.req_ctrl >> (32'(sel_idx_c) * CTRL_W));
         fu_a_c      = DATA_W'(bus.req_a >> (32'(sel_idx_c) * DATA_W));
         fu_b_c      = DATA_W'(bus.req_b >> (32'(sel_idx_c) * DATA_W));
         tag_d       = TAG_W'(bus.req_tag >> (32'(sel_idx_c) * TAG_W));
         cnt_d       = CNT_W'(LATENCY - 1);
         state_d     = EXEC;
`ifdef FU_ALU_RR_EN
         rr_ptr_d    = (32'(sel_idx_c) == NREQ - 1) ? '0 : sel_idx_c + IDX_W'(1);
`endif
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         tag_q         <= '0;
         wb_valid_q    <= 1'b0;
         wb_tag_q      <= '0;
         wb_data_q     <= '0;
         wb_zero_q     <= 1'b0;
         wb_overflow_q <= 1'b0;
         busy_q        <= 1'b0;
`ifdef FU_ALU_RR_EN
         rr_ptr_q      <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tag_q         <= tag_d;
         wb_valid_q    <= wb_valid_d;
         wb_tag_q      <= wb_tag_d;
         wb_data_q     <= wb_data_d;
         wb_zero_q     <= wb_zero_d;
         wb_overflow_q <= wb_overflow_d;
         busy_q        <= busy_d;
`ifdef FU_ALU_RR_EN
         rr_ptr_q      <= rr_ptr_d;
`endif
      end
   end

   // Grant and ALU drive are same-cycle; writeback and busy come from flops
   assign bus.req_grant   = req_grant_c;
   assign bus.fu_en       = fu_en_c;
   assign bus.fu_ctrl     = fu_ctrl_c;
   assign bus.fu_a        = fu_a_c;
   assign bus.fu_b        = fu_b_c;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_tag      = wb_tag_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.wb_zero     = wb_zero_q;
   assign bus.wb_overflow = wb_overflow_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_fu_alu_issue_arbiter.sv
// Self-checking bench for fu_alu_issue_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference (pending ops, issue time, expected writeback).
module tb_fu_alu_issue_arbiter;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned TAG_W = 3;
   localparam int unsigned LAT   = 2;
   localparam int unsigned LAT4  = 4;
   localparam int unsigned CW    = 4 * NREQ;
   localparam int unsigned DW    = 32 * NREQ;
   localparam int unsigned TW    = TAG_W * NREQ;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fu_alu_issue_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();
   fu_alu_issue_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus4 ();

   fu_alu_issue_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   fu_alu_issue_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .LATENCY(LAT4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4));

   int errors = 0;
   int checks = 0;

   // requester op table driven onto bus
   logic [NREQ-1:0]  r_valid;
   logic [3:0]       r_ctrl [NREQ];
   logic [31:0]      r_a    [NREQ];
   logic [31:0]      r_b    [NREQ];
   logic [TAG_W-1:0] r_tag  [NREQ];

   // ALU behaviour: {overflow, zero, result}
   function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        ov;
      r  = '0;
      ov = 1'b0;
      case (op)
         4'd1: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd2: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd3: r = a & b;
         4'd4: r = a | b;
         4'd5: r = a ^ b;
         default: r = '0;
      endcase
      return {ov, (r == 32'd0), r};
   endfunction

   // ALU stand-ins: latch operands on fu_en, hold the result until the next enable
   logic [33:0] alu_q, alu4_q;
   always @(posedge clk) begin
      if (!rst_n) alu_q <= '0;
      else if (bus.fu_en) alu_q <= alu_fn(bus.fu_ctrl, bus.fu_a, bus.fu_b);
   end
   always @(posedge clk) begin
      if (!rst_n) alu4_q <= '0;
      else if (bus4.fu_en) alu4_q <= alu_fn(bus4.fu_ctrl, bus4.fu_a, bus4.fu_b);
   end
   assign bus.fu_res       = alu_q[31:0];
   assign bus.fu_zero      = alu_q[32];
   assign bus.fu_overflow  = alu_q[33];
   assign bus4.fu_res      = alu4_q[31:0];
   assign bus4.fu_zero     = alu4_q[32];
   assign bus4.fu_overflow = alu4_q[33];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      logic [CW-1:0] c;
      logic [DW-1:0] a, b;
      logic [TW-1:0] t;
      c = '0; a = '0; b = '0; t = '0;
      for (int i = 0; i < NREQ; i++) begin
         c = c | (CW'(r_ctrl[i]) << (4 * i));
         a = a | (DW'(r_a[i]) << (32 * i));
         b = b | (DW'(r_b[i]) << (32 * i));
         t = t | (TW'(r_tag[i]) << (TAG_W * i));
      end
      bus.req_valid = r_valid;
      bus.req_ctrl  = c;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_tag   = t;
   endtask

   task automatic set_op(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
      r_valid[i] = 1'b1;
      r_ctrl[i]  = op;
      r_a[i]     = a;
      r_b[i]     = b;
      r_tag[i]   = tag;
   endtask

   task automatic do_reset();
      r_valid = '0;
      drive();
      bus.wb_ack = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      r_valid = '0;
      drive();
      bus.wb_ack = 1'b0;
      step();
      step();
      #2;
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
      checks++; if (bus.wb_tag !== 3'd0) begin errors++; $display("FAIL reset_wb_tag: got %0d want 0", bus.wb_tag); end
      checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %0h want 0", bus.wb_data); end
      checks++; if ({bus.wb_zero, bus.wb_overflow} !== 2'b00) begin errors++; $display("FAIL reset_wb_flags: got %b want 00", {bus.wb_zero, bus.wb_overflow}); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if ({bus.req_grant, bus.fu_en} !== 5'b0) begin errors++; $display("FAIL reset_grant_en: got %b want 0", {bus.req_grant, bus.fu_en}); end
      checks++; if ({bus4.busy, bus4.wb_valid} !== 2'b00) begin errors++; $display("FAIL reset_dut4: got %b want 00", {bus4.busy, bus4.wb_valid}); end
      rst_n = 1'b1;
      step();
   endtask

   // single ADD 5+7 with immediate ack
   task automatic test_basic();
      set_op(0, 4'd1, 32'd5, 32'd7, 3'd3);
      drive();
      bus.wb_ack = 1'b1;
      #2;
      checks++; if (bus.req_grant !== 4'b0001) begin errors++; $display("FAIL basic_grant: got %b want 0001", bus.req_grant); end
      checks++; if ({bus.fu_en, bus.fu_ctrl, bus.fu_a, bus.fu_b} !== {1'b1, 4'd1, 32'd5, 32'd7}) begin errors++; $display("FAIL basic_fu_drive: got en=%b ctrl=%0d a=%0d b=%0d want 1/1/5/7", bus.fu_en, bus.fu_ctrl, bus.fu_a, bus.fu_b); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_c0: got %b want 0", bus.busy); end
      step();
      r_valid = '0;
      drive();
      #2;
      checks++; if ({bus.wb_valid, bus.busy, bus.fu_en} !== 3'b010) begin errors++; $display("FAIL basic_c1: got valid/busy/en=%b want 010", {bus.wb_valid, bus.busy, bus.fu_en}); end
      checks++; if (bus.fu_a !== 32'd0) begin errors++; $display("FAIL basic_fu_a_idle: got %0h want 0", bus.fu_a); end
      step();
      #2;
      checks++; if ({bus.wb_valid, bus.wb_data, bus.wb_tag} !== {1'b1, 32'd12, 3'd3}) begin errors++; $display("FAIL basic_wb: got v=%b d=%0d t=%0d want 1/12/3", bus.wb_valid, bus.wb_data, bus.wb_tag); end
      step();
      #2;
      checks++; if ({bus.busy, bus.wb_valid} !== 2'b00) begin errors++; $display("FAIL basic_idle: got busy/valid=%b want 00", {bus.busy, bus.wb_valid}); end
      bus.wb_ack = 1'b0;
      step();
   endtask

   // writeback held under back-pressure; pending requester granted in the ack cycle
   task automatic test_hold();
      set_op(0, 4'd1, 32'd5, 32'd7, 3'd3);
      drive();
      bus.wb_ack = 1'b0;
      #2;
      checks++; if (bus.req_grant !== 4'b0001) begin errors++; $display("FAIL hold_first_grant: got %b want 0001", bus.req_grant); end
      step();
      r_valid = '0;
      set_op(1, 4'd2, 32'd20, 32'd4, 3'd5);
      drive();
      #2;
      checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("FAIL hold_exec_grant: got %b want 0000", bus.req_grant); end
      step();
      for (int k = 0; k < 5; k++) begin
         #2;
         checks++; if ({bus.wb_valid, bus.wb_data, bus.wb_tag} !== {1'b1, 32'd12, 3'd3}) begin errors++; $display("FAIL hold_wb_stable[%0d]: got v=%b d=%0d t=%0d want 1/12/3", k, bus.wb_valid, bus.wb_data, bus.wb_tag); end
         checks++; if ({bus.req_grant, bus.busy} !== 5'b00001) begin errors++; $display("FAIL hold_no_grant[%0d]: got grant=%b busy=%b want 0000/1", k, bus.req_grant, bus.busy); end
         step();
      end
      bus.wb_ack = 1'b1;
      #2;
      checks++; if ({bus.req_grant, bus.fu_en, bus.fu_a} !== {4'b0010, 1'b1, 32'd20}) begin errors++; $display("FAIL hold_ack_grant: got grant=%b en=%b a=%0d want 0010/1/20", bus.req_grant, bus.fu_en, bus.fu_a); end
      step();
      r_valid = '0;
      drive();
      bus.wb_ack = 1'b0;
      #2;
      checks++; if ({bus.wb_valid, bus.busy} !== 2'b01) begin errors++; $display("FAIL hold_second_exec: got valid/busy=%b want 01", {bus.wb_valid, bus.busy}); end
      step();
      #2;
      checks++; if ({bus.wb_valid, bus.wb_data, bus.wb_tag} !== {1'b1, 32'd16, 3'd5}) begin errors++; $display("FAIL hold_second_wb: got v=%b d=%0d t=%0d want 1/16/5", bus.wb_valid, bus.wb_data, bus.wb_tag); end
      bus.wb_ack = 1'b1;
      step();
      #2;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_final_idle: got %b want 0", bus.busy); end
      bus.wb_ack = 1'b0;
      step();
   endtask

   // all requesters held valid with ack: arbitration order every LATENCY cycles
   task automatic test_back_to_back();
      int exp_idx, prev_idx;
      logic [NREQ-1:0] exp_grant;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_op(i, 4'd1, 32'(i + 1), 32'(i), TAG_W'(i));
      drive();
      bus.wb_ack = 1'b1;
      for (int n = 0; n < 10; n++) begin
`ifdef FU_ALU_RR_EN
         exp_idx  = (n / 2) % NREQ;
         prev_idx = (n / 2 + NREQ - 1) % NREQ;
`else
         exp_idx  = 0;
         prev_idx = 0;
`endif
         exp_grant = (n % 2 == 0) ? (NREQ'(1) << exp_idx) : '0;
         #2;
         checks++; if (bus.req_grant !== exp_grant) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", n, bus.req_grant, exp_grant); end
         if (n >= 2 && n % 2 == 0) begin
            checks++; if ({bus.wb_valid, bus.wb_tag} !== {1'b1, TAG_W'(prev_idx)}) begin errors++; $display("FAIL b2b_wb[%0d]: got v=%b t=%0d want 1/%0d", n, bus.wb_valid, bus.wb_tag, prev_idx); end
         end
         step();
      end
      r_valid = '0;
      drive();
      repeat (4) step();
      bus.wb_ack = 1'b0;
   endtask

   // SUB overflow and zero flags captured into wb_*
   task automatic test_flags();
      logic [31:0] a, b, exp_d;
      for (int k = 0; k < 2; k++) begin
         a     = (k == 0) ? 32'h8000_0000 : 32'd9;
         b     = (k == 0) ? 32'd1 : 32'd9;
         exp_d = (k == 0) ? 32'h7FFF_FFFF : 32'd0;
         set_op(2, 4'd2, a, b, 3'd6);
         drive();
         bus.wb_ack = 1'b1;
         step();
         r_valid = '0;
         drive();
         step();
         #2;
         checks++; if (bus.wb_data !== exp_d) begin errors++; $display("FAIL flags_data[%0d]: got %0h want %0h", k, bus.wb_data, exp_d); end
         checks++; if ({bus.wb_valid, bus.wb_overflow, bus.wb_zero} !== {1'b1, (k == 0), (k == 1)}) begin errors++; $display("FAIL flags_vo_z[%0d]: got %b want %b", k, {bus.wb_valid, bus.wb_overflow, bus.wb_zero}, {1'b1, (k == 0), (k == 1)}); end
         step();
      end
      bus.wb_ack = 1'b0;
   endtask

   // reset during EXEC drops the op; a fresh op completes normally
   task automatic test_reset_mid();
      set_op(0, 4'd1, 32'd100, 32'd23, 3'd4);
      drive();
      bus.wb_ack = 1'b1;
      step();
      r_valid = '0;
      drive();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #2;
         checks++; if ({bus.busy, bus.wb_valid} !== 2'b00) begin errors++; $display("FAIL rstmid_quiet[%0d]: got busy/valid=%b want 00", k, {bus.busy, bus.wb_valid}); end
         step();
      end
      set_op(1, 4'd1, 32'd1, 32'd1, 3'd2);
      drive();
      #2;
      checks++; if (bus.req_grant !== 4'b0010) begin errors++; $display("FAIL rstmid_grant: got %b want 0010", bus.req_grant); end
      step();
      r_valid = '0;
      drive();
      step();
      #2;
      checks++; if ({bus.wb_valid, bus.wb_data, bus.wb_tag} !== {1'b1, 32'd2, 3'd2}) begin errors++; $display("FAIL rstmid_wb: got v=%b d=%0d t=%0d want 1/2/2", bus.wb_valid, bus.wb_data, bus.wb_tag); end
      step();
      bus.wb_ack = 1'b0;
   endtask

   // LATENCY=4 instance: wb_valid rises exactly 4 cycles after fu_en
   task automatic test_latency4();
      bus4.req_valid = 4'b0001;
      bus4.req_ctrl  = CW'(4'd1);
      bus4.req_a     = DW'(32'd3);
      bus4.req_b     = DW'(32'd4);
      bus4.req_tag   = TW'(3'd1);
      bus4.wb_ack    = 1'b1;
      #2;
      checks++; if ({bus4.fu_en, bus4.req_grant} !== 5'b10001) begin errors++; $display("FAIL lat4_issue: got en/grant=%b want 10001", {bus4.fu_en, bus4.req_grant}); end
      step();
      bus4.req_valid = '0;
      for (int k = 1; k <= 4; k++) begin
         #2;
         checks++; if (bus4.wb_valid !== (k == 4)) begin errors++; $display("FAIL lat4_valid[%0d]: got %b want %b", k, bus4.wb_valid, (k == 4)); end
         if (k == 4) begin
            checks++; if ({bus4.wb_data, bus4.wb_tag} !== {32'd7, 3'd1}) begin errors++; $display("FAIL lat4_wb: got d=%0d t=%0d want 7/1", bus4.wb_data, bus4.wb_tag); end
         end
         step();
      end
      #2;
      checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL lat4_idle: got %b want 0", bus4.busy); end
      bus4.wb_ack = 1'b0;
      step();
   endtask

   // randomized requests and back-pressure against a transaction-level reference
   task automatic test_random();
      bit              inflight, wbvis, can;
      int              issue_cyc, s, idx, mptr;
      logic [NREQ-1:0] exp_grant;
      logic [33:0]     exp_res;
      logic [TAG_W-1:0] exp_tag;
      do_reset();
      inflight = 1'b0; issue_cyc = 0; mptr = 0; exp_res = '0; exp_tag = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!r_valid[i] && $urandom_range(0, 2) == 0) begin
               r_ctrl[i]  = 4'($urandom_range(1, 5));
               r_a[i]     = $urandom;
               r_b[i]     = ($urandom_range(0, 5) == 0) ? r_a[i] : $urandom;
               r_tag[i]   = TAG_W'($urandom);
               r_valid[i] = 1'b1;
            end
         end
         bus.wb_ack = ($urandom_range(0, 1) == 1);
         drive();
         wbvis = inflight && (cyc >= issue_cyc + int'(LAT));
         can   = !inflight || (wbvis && bus.wb_ack);
         s = -1;
         if (can) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef FU_ALU_RR_EN
               idx = (mptr + k) % NREQ;
`else
               idx = k;
`endif
               if (s < 0 && r_valid[idx]) s = idx;
            end
         end
         exp_grant = (s >= 0) ? (NREQ'(1) << s) : '0;
         #2;
         checks++; if ({bus.req_grant, bus.fu_en} !== {exp_grant, (s >= 0)}) begin errors++; $display("FAIL rand_grant[%0d]: got %b/%b want %b/%b", cyc, bus.req_grant, bus.fu_en, exp_grant, (s >= 0)); end
         checks++; if ({bus.busy, bus.wb_valid} !== {inflight, wbvis}) begin errors++; $display("FAIL rand_state[%0d]: got busy/valid=%b want %b", cyc, {bus.busy, bus.wb_valid}, {inflight, wbvis}); end
         if (wbvis) begin
            checks++; if ({bus.wb_overflow, bus.wb_zero, bus.wb_data, bus.wb_tag} !== {exp_res, exp_tag}) begin errors++; $display("FAIL rand_wb[%0d]: got o=%b z=%b d=%h t=%0d want %h t=%0d", cyc, bus.wb_overflow, bus.wb_zero, bus.wb_data, bus.wb_tag, exp_res, exp_tag); end
         end
         if (s >= 0) begin
            checks++; if ({bus.fu_ctrl, bus.fu_a, bus.fu_b} !== {r_ctrl[s], r_a[s], r_b[s]}) begin errors++; $display("FAIL rand_fu[%0d]: got %0d/%h/%h want %0d/%h/%h", cyc, bus.fu_ctrl, bus.fu_a, bus.fu_b, r_ctrl[s], r_a[s], r_b[s]); end
         end
         if (wbvis && bus.wb_ack) inflight = 1'b0;
         if (s >= 0) begin
            inflight   = 1'b1;
            issue_cyc  = cyc;
            exp_res    = alu_fn(r_ctrl[s], r_a[s], r_b[s]);
            exp_tag    = r_tag[s];
            r_valid[s] = 1'b0;
            mptr       = (s + 1) % NREQ;
         end
         step();
      end
      r_valid = '0;
      drive();
      bus.wb_ack = 1'b1;
      repeat (LAT + 2) step();
      bus.wb_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      r_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         r_ctrl[i] = '0; r_a[i] = '0; r_b[i] = '0; r_tag[i] = '0;
      end
      drive();
      bus.wb_ack     = 1'b0;
      bus4.req_valid = '0;
      bus4.req_ctrl  = '0;
      bus4.req_a     = '0;
      bus4.req_b     = '0;
      bus4.req_tag   = '0;
      bus4.wb_ack    = 1'b0;

      test_reset();
      test_basic();
      test_hold();
      test_back_to_back();
      test_flags();
      test_reset_mid();
      test_latency4();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
